// File: rtl/mutex_arb_ctrl.sv
// Two-client four-phase front end for a downstream mutex: round-robin arbitration, registered mutex requests.
// Optional MUTEX_ARB_TIMEOUT_EN bounds each grant to MAX_HOLD cycles and blocks the offender until it withdraws.
module mutex_arb_ctrl #(
   parameter int MAX_HOLD = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   output logic ack_a,
   input  logic req_b,
   output logic ack_b,
   output logic mtx_x,
   output logic mtx_y,
   input  logic mtx_u,
   input  logic mtx_v,
   output logic busy,
   output logic last_a,
   output logic timeout
);

   typedef enum logic [1:0] {IDLE, ARB, GRANT, RELEASE} state_t;

   state_t     state, state_nxt;
   logic       win_a, win_a_nxt;
   logic       granted, granted_nxt;
   logic       ack_a_nxt, ack_b_nxt;
   logic       mtx_x_nxt, mtx_y_nxt;
   logic       last_a_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic       elig_a, elig_b, pick_a;
   logic       win_req, win_gnt;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mutex_arb_ctrl: MAX_HOLD must lie in 2..255");
   end

`ifdef MUTEX_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic blocked_a, blocked_b, blocked_a_nxt, blocked_b_nxt;
   logic timeout_q, timeout_nxt;

   assign elig_a  = req_a & ~blocked_a;
   assign elig_b  = req_b & ~blocked_b;
   assign timeout = timeout_q;
`else
   assign elig_a  = req_a;
   assign elig_b  = req_b;
   assign timeout = 1'b0;
`endif

   // On a tie the client that did not hold the last completed grant wins.
   assign pick_a  = elig_a & (~elig_b | ~last_a);
   assign win_req = win_a ? req_a : req_b;
   assign win_gnt = win_a ? mtx_u : mtx_v;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      win_a_nxt    = win_a;
      granted_nxt  = granted;
      ack_a_nxt    = ack_a;
      ack_b_nxt    = ack_b;
      mtx_x_nxt    = mtx_x;
      mtx_y_nxt    = mtx_y;
      last_a_nxt   = last_a;
      hold_cnt_nxt = hold_cnt;
`ifdef MUTEX_ARB_TIMEOUT_EN
      timeout_nxt   = timeout_q;
      blocked_a_nxt = blocked_a & req_a;
      blocked_b_nxt = blocked_b & req_b;
`endif
      case (state)
         IDLE: begin
            if (elig_a || elig_b) begin
               win_a_nxt   = pick_a;
               granted_nxt = 1'b0;
               mtx_x_nxt   = pick_a;
               mtx_y_nxt   = ~pick_a;
               state_nxt   = ARB;
            end
         end
         ARB: begin
            // A withdrawn request beats a grant arriving in the same cycle.
            if (!win_req) begin
               mtx_x_nxt = 1'b0;
               mtx_y_nxt = 1'b0;
               state_nxt = RELEASE;
            end else if (win_gnt) begin
               ack_a_nxt    = win_a;
               ack_b_nxt    = ~win_a;
               granted_nxt  = 1'b1;
               hold_cnt_nxt = 8'd0;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            hold_cnt_nxt = hold_cnt + 8'd1;
            if (!win_req) begin
               ack_a_nxt = 1'b0;
               ack_b_nxt = 1'b0;
               mtx_x_nxt = 1'b0;
               mtx_y_nxt = 1'b0;
               state_nxt = RELEASE;
            end
`ifdef MUTEX_ARB_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST) begin
               ack_a_nxt   = 1'b0;
               ack_b_nxt   = 1'b0;
               mtx_x_nxt   = 1'b0;
               mtx_y_nxt   = 1'b0;
               timeout_nxt = 1'b1;
               if (win_a) blocked_a_nxt = 1'b1;
               else       blocked_b_nxt = 1'b1;
               state_nxt   = RELEASE;
            end
`endif
         end
         RELEASE: begin
            if (!mtx_u && !mtx_v) begin
               if (granted) last_a_nxt = win_a;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         win_a    <= 1'b0;
         granted  <= 1'b0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         mtx_x    <= 1'b0;
         mtx_y    <= 1'b0;
         last_a   <= 1'b0;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         win_a    <= win_a_nxt;
         granted  <= granted_nxt;
         ack_a    <= ack_a_nxt;
         ack_b    <= ack_b_nxt;
         mtx_x    <= mtx_x_nxt;
         mtx_y    <= mtx_y_nxt;
         last_a   <= last_a_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

`ifdef MUTEX_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
         blocked_a <= 1'b0;
         blocked_b <= 1'b0;
      end else begin
         timeout_q <= timeout_nxt;
         blocked_a <= blocked_a_nxt;
         blocked_b <= blocked_b_nxt;
      end
   end
`endif

endmodule
